// File: rtl/sobol_seq_gen.sv
// Multi-dimensional Sobol quasi-random sequence generator (gray-code order).
// Owns the point counter and a runtime-loadable direction table per dimension.
module sobol_seq_gen #(
    parameter int W  = 6,
    parameter int D  = 4,
    parameter int DW = (D > 1) ? $clog2(D) : 1,
    parameter int KW = (W > 1) ? $clog2(W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [DW-1:0]     cfg_dim,
    input  logic [KW-1:0]     cfg_idx,
    input  logic [W-1:0]      cfg_data,
    input  logic              start,
    input  logic [W-1:0]      len,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [D*W-1:0]    out_data,
    output logic [W-1:0]      out_index,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   tbl [D][W];
    logic [W-1:0]   len_q;
    logic [KW-1:0]  step_idx;
    logic [D*W-1:0] step_data;
    logic [W-1:0]   next_index;
    logic           handshake;
    logic           last_point;
    logic           cfg_hit;

    assign next_index = out_index + W'(1);
    assign handshake  = out_valid && out_ready;
    assign last_point = (next_index == len_q);
    assign cfg_hit    = cfg_we && (int'(cfg_dim) < D) && (int'(cfg_idx) < W);

    // Index of the lowest zero bit of n; n stays below 2^W-1 so one always exists.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        step_idx = '0;
        for (int k = W - 1; k >= 0; k--) begin
            if (!out_index[k]) step_idx = KW'(k);
        end
    end

    always_comb begin
        step_data = out_data;
        for (int d = 0; d < D; d++) begin
            for (int k = 0; k < W; k++) begin
                if (int'(step_idx) == k) step_data[d*W +: W] = out_data[d*W +: W] ^ tbl[d][k];
            end
        end
    end

    // NOTE: the direction table is reset on purpose: after rst it must hold the
    // van der Corput defaults, so it lives in the async-reset block like any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            len_q     <= '0;
            for (int d = 0; d < D; d++) begin
                for (int k = 0; k < W; k++) begin
                    tbl[d][k] <= W'(1) << (W - 1 - k);
                end
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every read sees pre-edge state.
            case (state)
                S_IDLE: begin
                    if (cfg_hit) tbl[cfg_dim][cfg_idx] <= cfg_data;
                    if (start) begin
                        len_q <= len;
                        if (len != '0) begin
                            out_data  <= '0;
                            out_index <= '0;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (handshake) begin
                        if (last_point) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            out_data  <= step_data;
                            out_index <= next_index;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobol_seq_gen.sv
// Scoreboard bench for sobol_seq_gen: expected points come from the closed form
// x_n = XOR of V[k] over the set bits of gray(n), checked by an output monitor.
module tb_sobol_seq_gen;

    localparam int W  = 6;
    localparam int D  = 4;
    localparam int DW = 2;
    localparam int KW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cfg_we = 1'b0;
    logic [DW-1:0]  cfg_dim = '0;
    logic [KW-1:0]  cfg_idx = '0;
    logic [W-1:0]   cfg_data = '0;
    logic           start = 1'b0;
    logic [W-1:0]   len = '0;
    logic           out_ready = 1'b0;
    logic           out_valid;
    logic [D*W-1:0] out_data;
    logic [W-1:0]   out_index;
    logic           busy;
    logic           done;

    // Second build: D=1, W=8
    logic           b_cfg_we = 1'b0;
    logic [0:0]     b_cfg_dim = '0;
    logic [2:0]     b_cfg_idx = '0;
    logic [7:0]     b_cfg_data = '0;
    logic           b_start = 1'b0;
    logic [7:0]     b_len = '0;
    logic           b_ready = 1'b0;
    logic           b_valid;
    logic [7:0]     b_data;
    logic [7:0]     b_index;
    logic           b_busy;
    logic           b_done;

    always #5 clk = ~clk;

    sobol_seq_gen #(.W(W), .D(D)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_dim   (cfg_dim),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .start     (start),
        .len       (len),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .done      (done)
    );

    sobol_seq_gen #(.W(8), .D(1)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (b_cfg_we),
        .cfg_dim   (b_cfg_dim),
        .cfg_idx   (b_cfg_idx),
        .cfg_data  (b_cfg_data),
        .start     (b_start),
        .len       (b_len),
        .out_ready (b_ready),
        .out_valid (b_valid),
        .out_data  (b_data),
        .out_index (b_index),
        .busy      (b_busy),
        .done      (b_done)
    );

    typedef struct {
        logic [W-1:0]   idx;
        logic [D*W-1:0] data;
    } exp_t;

    exp_t           qexp[$];
    exp_t           e;
    int             errors = 0;
    int             checks = 0;
    int             popped = 0;
    logic [W-1:0]   mv [D][W];
    logic           stalled = 1'b0;
    logic [W-1:0]   hold_idx;
    logic [D*W-1:0] hold_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < D; d++)
            for (int k = 0; k < W; k++)
                mv[d][k] = W'(1) << (W - 1 - k);
    endfunction

    function automatic logic [D*W-1:0] model_point(input int n);
        int g;
        logic [D*W-1:0] r;
        g = n ^ (n >> 1);
        r = '0;
        for (int d = 0; d < D; d++)
            for (int k = 0; k < W; k++)
                if (g[k]) r[d*W +: W] = r[d*W +: W] ^ mv[d][k];
        return r;
    endfunction

    // Monitor: pops on each accepted point and checks stability while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) begin
                check("stall_data", 64'(out_data), 64'(hold_data));
                check("stall_index", 64'(out_index), 64'(hold_idx));
            end
            if (out_valid && out_ready) begin
                if (qexp.size() == 0) begin
                    check("unexpected_point", 64'(out_index), 64'hFFFF);
                end else begin
                    e = qexp.pop_front();
                    check("pt_data", 64'(out_data), 64'(e.data));
                    check("pt_index", 64'(out_index), 64'(e.idx));
                    popped++;
                end
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled   = 1'b1;
                hold_data = out_data;
                hold_idx  = out_index;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int d, input int k, input logic [W-1:0] v);
        cfg_we   = 1'b1;
        cfg_dim  = DW'(d);
        cfg_idx  = KW'(k);
        cfg_data = v;
        tick();
        cfg_we   = 1'b0;
        mv[d][k] = v;
    endtask

    // mode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0
    // disturb: 1 cfg_we+start during RUN, 2 cfg_we together with start
    task automatic run_seq(input int n_pts, input int mode, input int disturb);
        int cyc;
        if (disturb == 2) mv[2][0] = W'(7);
        for (int i = 0; i < n_pts; i++) qexp.push_back('{W'(i), model_point(i)});
        popped = 0;
        len    = W'(n_pts);
        start  = 1'b1;
        if (disturb == 2) begin
            cfg_we   = 1'b1;
            cfg_dim  = DW'(2);
            cfg_idx  = '0;
            cfg_data = W'(7);
        end
        out_ready = (mode != 1);
        tick();
        start  = 1'b0;
        cfg_we = 1'b0;
        cyc = 0;
        while (!done && cyc < 1000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc % 3 == 0);
            endcase
            if (disturb == 1 && cyc == 2) begin
                cfg_we   = 1'b1;
                cfg_dim  = '0;
                cfg_idx  = '0;
                cfg_data = W'(5);
                start    = 1'b1;
                len      = W'(3);
            end
            tick();
            cfg_we = 1'b0;
            start  = 1'b0;
            len    = W'(n_pts);
            cyc++;
        end
        check("done_seen", 64'(done), 64'(1));
        check("points_accepted", 64'(popped), 64'(n_pts));
        check("busy_at_done", 64'(busy), 64'(0));
        check("valid_at_done", 64'(out_valid), 64'(0));
        if (n_pts == 0) check("len0_done_latency", 64'(cyc), 64'(0));
        if (n_pts > 0) check("last_index", 64'(out_index), 64'(n_pts - 1));
        out_ready = 1'b0;
        tick();
        check("done_one_cycle", 64'(done), 64'(0));
        qexp.delete();
    endtask

    initial begin
        logic [7:0] b_exp [4];
        int         cyc;
        b_exp = '{8'd0, 8'd128, 8'd192, 8'd64};
        model_reset();

        // Reset state
        #23;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst = 1'b1;
        tick();
        check("idle_done", 64'(done), 64'(0));
        check("idle_index", 64'(out_index), 64'(0));

        // Default table, full rate
        run_seq(5, 0, 0);
        // Loaded dim1 table
        cfg_write(1, 0, W'(32));
        cfg_write(1, 1, W'(48));
        cfg_write(1, 2, W'(40));
        cfg_write(1, 3, W'(28));
        cfg_write(1, 4, W'(18));
        cfg_write(1, 5, W'(11));
        run_seq(5, 0, 0);
        // Backpressure pattern and random ready
        run_seq(5, 2, 0);
        run_seq(12, 1, 0);
        // len boundaries
        run_seq(0, 0, 0);
        run_seq(63, 0, 0);
        // Ignored cfg/start during RUN; cfg with start
        run_seq(10, 0, 1);
        run_seq(6, 0, 2);

        // Random tables and lengths
        for (int t = 0; t < 6; t++) begin
            for (int d = 0; d < D; d++)
                for (int k = 0; k < W; k++)
                    cfg_write(d, k, W'($urandom));
            run_seq(int'($urandom_range(1, 40)), 1, 0);
        end

        // Reset in the middle of a sequence
        for (int i = 0; i < 10; i++) qexp.push_back('{W'(i), model_point(i)});
        len       = W'(10);
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (out_index != W'(2) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("reach_index2", 64'(out_index), 64'(2));
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_data", 64'(out_data), 64'(0));
        check("async_rst_index", 64'(out_index), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        qexp.delete();
        model_reset();
        #3;
        rst = 1'b1;
        tick();
        tick();
        tick();
        check("no_point_after_rst", 64'(out_valid), 64'(0));
        run_seq(5, 0, 0);

        // D=1, W=8 build
        b_len   = 8'd4;
        b_start = 1'b1;
        b_ready = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b_valid", 64'(b_valid), 64'(1));
            check("b_data", 64'(b_data), 64'(b_exp[i]));
            check("b_index", 64'(b_index), 64'(i));
            tick();
        end
        check("b_done", 64'(b_done), 64'(1));
        b_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
